// File: rtl/spsr_bank_if.sv
// spsr_bank bus: exception-entry save, MSR write, read port and status.
// master drives requests; slave (spsr_bank) returns read data and flags.
interface spsr_bank_if #(
  parameter int DWIDTH = 32
);
  logic              exc_entry;
  logic [2:0]        exc_index;
  logic [DWIDTH-1:0] cpsr_in;
  logic              msr_wr;
  logic [2:0]        msr_index;
  logic [DWIDTH/8-1:0] msr_mask;
  logic [DWIDTH-1:0] msr_data;
  logic              msr_drop;
  logic [2:0]        rd_index;
  logic [DWIDTH-1:0] rd_data;
  logic              rd_valid;
  logic              parity_err;

  modport master (
    output exc_entry, exc_index, cpsr_in,
    output msr_wr, msr_index, msr_mask, msr_data,
    output rd_index,
    input  msr_drop, rd_data, rd_valid, parity_err
  );

  modport slave (
    input  exc_entry, exc_index, cpsr_in,
    input  msr_wr, msr_index, msr_mask, msr_data,
    input  rd_index,
    output msr_drop, rd_data, rd_valid, parity_err
  );
endinterface

// File: rtl/spsr_bank.sv
// Banked SPSRs with a 1-entry write buffer and forwarding read port.
// Ports: clk, rst (sync, high), bus (spsr_bank_if.slave). Opt: SPSR_PARITY_EN.
module spsr_bank #(
  parameter int DWIDTH = 32,
  parameter int NBANKS = 5
) (
  input logic      clk,
  input logic      rst,
  spsr_bank_if.slave bus
);
  localparam int MW = DWIDTH / 8;

  typedef logic [DWIDTH-1:0] word_t;
  typedef logic [MW-1:0]     mask_t;

  function automatic logic legal(input logic [2:0] i);
    return 32'(i) < NBANKS;
  endfunction

  function automatic word_t merge(input word_t o, input word_t n,
                                  input mask_t m);
    word_t r;
    r = o;
    for (int b = 0; b < MW; b++)
      if (m[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  word_t bank [NBANKS];

  logic       wb_valid;
  logic [2:0] wb_index;
  word_t      wb_data;
  mask_t      wb_mask;

  word_t rd_data_q;
  logic  rd_valid_q;
  logic  drop_q;
  logic  perr_q;

  logic       exc_ok, msr_ok, acc;
  logic [2:0] acc_idx;
  word_t      acc_data;
  mask_t      acc_mask;

  logic  rd_ok, hit_wb, hit_acc;
  word_t bank_rd, fwd;

  always_comb begin
    exc_ok   = bus.exc_entry && legal(bus.exc_index);
    msr_ok   = bus.msr_wr && legal(bus.msr_index);
    acc      = exc_ok || msr_ok;
    acc_idx  = exc_ok ? bus.exc_index : bus.msr_index;
    acc_data = exc_ok ? bus.cpsr_in : bus.msr_data;
    acc_mask = exc_ok ? '1 : bus.msr_mask;
  end

  // Read view layers bank, then pending buffer, then this cycle's accept.
  always_comb begin
    bank_rd = '0;
    for (int i = 0; i < NBANKS; i++)
      if (bus.rd_index == 3'(i)) bank_rd = bank[i];
    rd_ok   = legal(bus.rd_index);
    hit_wb  = wb_valid && (wb_index == bus.rd_index);
    hit_acc = acc && (acc_idx == bus.rd_index);
    fwd     = bank_rd;
    if (hit_wb)  fwd = merge(fwd, wb_data, wb_mask);
    if (hit_acc) fwd = merge(fwd, acc_data, acc_mask);
  end

`ifdef SPSR_PARITY_EN
  logic par [NBANKS];
  logic par_rd;

  always_comb begin
    par_rd = 1'b0;
    for (int i = 0; i < NBANKS; i++)
      if (bus.rd_index == 3'(i)) par_rd = par[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NBANKS; i++) par[i] <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      for (int i = 0; i < NBANKS; i++)
        if (wb_valid && wb_index == 3'(i))
          par[i] <= ^merge(bank[i], wb_data, wb_mask);
      // Forwarded reads bypass the stored word, so never flag them.
      perr_q <= rd_ok && !hit_wb && !hit_acc &&
                ((^bank_rd) != par_rd);
    end
  end
`else
  always_ff @(posedge clk) begin
    perr_q <= 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NBANKS; i++) bank[i] <= '0;
      wb_valid   <= 1'b0;
      wb_index   <= '0;
      wb_data    <= '0;
      wb_mask    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      // Commit uses the old buffer; a same-edge accept reloads it.
      for (int i = 0; i < NBANKS; i++)
        if (wb_valid && wb_index == 3'(i))
          bank[i] <= merge(bank[i], wb_data, wb_mask);
      wb_valid <= acc;
      if (acc) begin
        wb_index <= acc_idx;
        wb_data  <= acc_data;
        wb_mask  <= acc_mask;
      end
      rd_valid_q <= rd_ok;
      rd_data_q  <= rd_ok ? fwd : '0;
      drop_q     <= exc_ok && msr_ok;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.msr_drop   = drop_q;
  assign bus.parity_err = perr_q;
endmodule

// File: tb/tb_spsr_bank.sv
// Testbench for spsr_bank: architectural model + 1-cycle scoreboard.
// Drives the bus interface; compares rd_data/rd_valid/msr_drop/parity_err.
module tb_spsr_bank;
  localparam int DW = 32;
  localparam int NB = 5;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] data;
    logic          drop;
    logic          perr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spsr_bank_if #(.DWIDTH(DW)) bus ();

  spsr_bank #(.DWIDTH(DW), .NBANKS(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mbank [8];
  exp_t q [$];
  logic perr_exp = 1'b0;
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] mrg(input logic [DW-1:0] o,
                                        input logic [DW-1:0] n,
                                        input logic [3:0] m);
    logic [DW-1:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic idle_in();
    bus.exc_entry = 0; bus.exc_index = 0; bus.cpsr_in = 0;
    bus.msr_wr = 0; bus.msr_index = 0; bus.msr_mask = 0;
    bus.msr_data = 0; bus.rd_index = 0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mbank[i] = '0;
  endtask

  // One cycle: drive, update the architectural model, push, then check.
  task automatic cyc(input logic ee, input logic [2:0] ei,
                     input logic [DW-1:0] cp, input logic mw,
                     input logic [2:0] mi, input logic [3:0] mm,
                     input logic [DW-1:0] md, input logic [2:0] ri,
                     input string tag);
    exp_t e, g;
    logic eok, mok;
    bus.exc_entry = ee; bus.exc_index = ei; bus.cpsr_in = cp;
    bus.msr_wr = mw; bus.msr_index = mi; bus.msr_mask = mm;
    bus.msr_data = md; bus.rd_index = ri;
    eok = ee && (int'(ei) < NB);
    mok = mw && (int'(mi) < NB);
    if (eok) mbank[ei] = cp;
    else if (mok) mbank[mi] = mrg(mbank[mi], md, mm);
    e.valid = int'(ri) < NB;
    e.data  = e.valid ? mbank[ri] : '0;
    e.drop  = eok && mok;
    e.perr  = perr_exp;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check({tag, "_q"}, 1, 0);
    end else begin
      e = q.pop_front();
      g.valid = bus.rd_valid; g.data = bus.rd_data;
      g.drop = bus.msr_drop; g.perr = bus.parity_err;
      check({tag, "_valid"}, 64'(g.valid), 64'(e.valid));
      check({tag, "_data"},  64'(g.data),  64'(e.data));
      check({tag, "_drop"},  64'(g.drop),  64'(e.drop));
      check({tag, "_perr"},  64'(g.perr),  64'(e.perr));
    end
  endtask

  task automatic rd(input logic [2:0] ri, input string tag);
    cyc(0, 0, 0, 0, 0, 0, 0, ri, tag);
  endtask

  initial begin
    do_reset();
    check("rst_valid", 64'(bus.rd_valid), 0);
    check("rst_data",  64'(bus.rd_data),  0);
    check("rst_drop",  64'(bus.msr_drop), 0);
    check("rst_perr",  64'(bus.parity_err), 0);

    // 1: reset reads
    for (int i = 0; i < 5; i++) rd(3'(i), "t1_rd");
    rd(7, "t1_rd7");

    // 2: exception entry save, forwarded then from bank
    cyc(1, 3, 32'h600000D2, 0, 0, 0, 0, 0, "t2_wr");
    rd(3, "t2_fwd");
    rd(0, "t2_gap");
    rd(0, "t2_gap");
    rd(3, "t2_bank");

    // 3: flags-only MSR merge
    cyc(1, 1, 32'h000000D3, 0, 0, 0, 0, 1, "t3_init");
    rd(0, "t3_gap");
    cyc(0, 0, 0, 1, 1, 4'b1000, 32'hF0000000, 1, "t3_msr");
    rd(1, "t3_rd");
    rd(1, "t3_rd2");

    // 4: priority and drop
    cyc(1, 0, 32'h10, 1, 2, 4'hF, 32'hDEADBEEF, 2, "t4_both");
    rd(0, "t4_b0");
    rd(2, "t4_b2");

    // 5: illegal indices
    cyc(0, 0, 0, 1, 7, 4'hF, 32'h12345678, 7, "t5_i7");
    cyc(0, 0, 0, 1, 5, 4'hF, 32'h87654321, 5, "t5_i5");
    cyc(1, 6, 32'hAAAA5555, 0, 0, 0, 0, 6, "t5_e6");
    for (int i = 0; i < 5; i++) rd(3'(i), "t5_all");

    // same-index accept + commit chain with partial masks
    cyc(0, 0, 0, 1, 2, 4'b0001, 32'h000000AA, 2, "sx_a");
    cyc(0, 0, 0, 1, 2, 4'b0010, 32'h0000BB00, 2, "sx_b");
    cyc(0, 0, 0, 1, 2, 4'b0001, 32'h000000CC, 2, "sx_c");
    rd(2, "sx_d");
    rd(2, "sx_e");

    // 6: back-to-back writes to index 4
    cyc(0, 0, 0, 1, 4, 4'hF, 32'h1, 4, "t6_w1");
    cyc(0, 0, 0, 1, 4, 4'hF, 32'h3, 4, "t6_w3");
    rd(4, "t6_rd");
    rd(4, "t6_rd2");
`ifdef SPSR_PARITY_EN
    dut.bank[4][5] = ~dut.bank[4][5];
    mbank[4][5] = ~mbank[4][5];
    perr_exp = 1'b1;
    rd(4, "t6_perr");
    perr_exp = 1'b0;
    rd(0, "t6_clr");
`endif

    // reset with a write still buffered
    cyc(1, 2, 32'hABCD0123, 0, 0, 0, 0, 2, "rp_wr");
    do_reset();
    rd(2, "rp_rd");

    // random traffic
    for (int n = 0; n < 300; n++) begin
      cyc(1'($urandom_range(0, 3) == 0), 3'($urandom), $urandom,
          1'($urandom), 3'($urandom), 4'($urandom), $urandom,
          3'($urandom), "rnd");
    end
    for (int i = 0; i < 5; i++) rd(3'(i), "fin");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end
endmodule
